// File: rtl/branch_resolve_updater.sv
// Branch resolve/update unit: queues IF-stage predictions, checks them against EX outcomes,
// and drives the predictor buffer write port. Optional BRU_STATS_EN adds branch/mispredict counters.
module branch_resolve_updater #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pred_valid,
    input  logic [PC_W-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    input  logic [1:0]      pred_state,
    input  logic            res_valid,
    input  logic            res_taken,
    input  logic [PC_W-1:0] res_target,
    output logic            update,
    output logic [PC_W-1:0] upd_pc,
    output logic [PC_W-1:0] upd_target,
    output logic [1:0]      upd_state,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic            q_full,
`ifdef BRU_STATS_EN
    output logic            q_empty,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
`else
    output logic            q_empty
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [PC_W-1:0] r_pc    [DEPTH];
    logic [PC_W-1:0] r_tgt   [DEPTH];
    logic            r_taken [DEPTH];
    logic [1:0]      r_state [DEPTH];
    logic [AW:0]     r_wr;
    logic [AW:0]     r_rd;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_mp;
    logic [PC_W-1:0] w_head_pc;
    logic [PC_W-1:0] w_head_tgt;
    logic            w_head_taken;
    logic [1:0]      w_head_state;
    logic [1:0]      w_new_state;
    logic [PC_W-1:0] w_upd_target;
    logic [PC_W-1:0] w_redirect;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign q_full  = w_full;
    assign q_empty = w_empty;

    always_comb begin
        w_head_pc    = r_pc[r_rd[AW-1:0]];
        w_head_tgt   = r_tgt[r_rd[AW-1:0]];
        w_head_taken = r_taken[r_rd[AW-1:0]];
        w_head_state = r_state[r_rd[AW-1:0]];
        w_pop        = res_valid && !w_empty;
        w_mp         = (w_head_taken != res_taken) ||
                       (res_taken && w_head_taken && (w_head_tgt != res_target));
        w_new_state  = w_head_state;
        if (res_taken) begin
            if (w_head_state != 2'b11) w_new_state = w_head_state + 2'b01;
        end else begin
            if (w_head_state != 2'b00) w_new_state = w_head_state - 2'b01;
        end
        w_upd_target = res_taken ? res_target : w_head_tgt;
        w_redirect   = res_taken ? res_target : (w_head_pc + PC_W'(4));
        // Wrong-path pushes: during the registered flush pulse and on the flushing pop edge
        w_push       = pred_valid && (!w_full || res_valid) && !mispredict && !(w_pop && w_mp);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr[AW-1:0]]    <= pred_pc;
            r_tgt[r_wr[AW-1:0]]   <= pred_target;
            r_taken[r_wr[AW-1:0]] <= pred_taken;
            r_state[r_wr[AW-1:0]] <= pred_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (w_pop && w_mp) begin
            r_rd <= r_rd + PTR_ONE;
            r_wr <= r_rd + PTR_ONE;
        end else begin
            if (w_pop)  r_rd <= r_rd + PTR_ONE;
            if (w_push) r_wr <= r_wr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            update      <= 1'b0;
            mispredict  <= 1'b0;
            upd_pc      <= '0;
            upd_target  <= '0;
            upd_state   <= '0;
            redirect_pc <= '0;
        end else begin
            update     <= w_pop;
            mispredict <= w_pop && w_mp;
            if (w_pop) begin
                upd_pc      <= w_head_pc;
                upd_target  <= w_upd_target;
                upd_state   <= w_new_state;
                redirect_pc <= w_redirect;
            end
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (w_pop)         br_count <= br_count + 32'd1;
            if (w_pop && w_mp) mp_count <= mp_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_updater.sv
// Self-checking bench for branch_resolve_updater: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_branch_resolve_updater;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic [1:0]      pred_state;
    logic            res_valid;
    logic            res_taken;
    logic [PC_W-1:0] res_target;
    logic            update;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic [1:0]      upd_state;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
    logic            q_full;
    logic            q_empty;
`ifdef BRU_STATS_EN
    logic [31:0]     br_count;
    logic [31:0]     mp_count;
    int unsigned     exp_br;
    int unsigned     exp_mc;
`endif

    branch_resolve_updater #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_state(pred_state),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .update(update), .upd_pc(upd_pc), .upd_target(upd_target), .upd_state(upd_state),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .q_full(q_full),
`ifdef BRU_STATS_EN
        .q_empty(q_empty), .br_count(br_count), .mp_count(mp_count)
`else
        .q_empty(q_empty)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic [1:0]  state;
    } ent_t;

    ent_t        mq[$];
    logic        exp_update, exp_mp;
    logic [31:0] exp_upd_pc, exp_upd_tgt, exp_redirect;
    logic [1:0]  exp_upd_state;
    int          total = 0;
    int          bad = 0;

    task automatic model_clear();
        mq.delete();
        exp_update = 0; exp_mp = 0;
        exp_upd_pc = 0; exp_upd_tgt = 0; exp_upd_state = 0; exp_redirect = 0;
`ifdef BRU_STATS_EN
        exp_br = 0; exp_mc = 0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 0; pred_valid = 0; res_valid = 0;
        pred_pc = 0; pred_taken = 0; pred_target = 0; pred_state = 0;
        res_taken = 0; res_target = 0;
        @(posedge clk); #1;
        rst_n = 1;
        model_clear();
    endtask

    // Drive one cycle of inputs, advance the reference model, sample 1 time unit after the edge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                        input logic [31:0] ptgt, input logic [1:0] ps,
                        input logic rv, input logic rt, input logic [31:0] rtgt);
        ent_t h;
        ent_t n;
        bit   pop, mp, push;
        int   s;
        pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt; pred_state = ps;
        res_valid = rv; res_taken = rt; res_target = rtgt;
        pop = rv && (mq.size() > 0);
        mp  = 0;
        if (pop) begin
            h  = mq[0];
            mp = (h.taken != rt) || (rt && h.tgt != rtgt);
        end
        push = pv && (mq.size() < DEPTH || rv) && !exp_mp && !(pop && mp);
        @(posedge clk); #1;
        exp_update = pop;
        exp_mp     = pop && mp;
        if (pop) begin
            void'(mq.pop_front());
            s = int'(h.state);
            s = rt ? ((s < 3) ? s + 1 : 3) : ((s > 0) ? s - 1 : 0);
            exp_upd_pc    = h.pc;
            exp_upd_tgt   = rt ? rtgt : h.tgt;
            exp_upd_state = 2'(s);
            exp_redirect  = rt ? rtgt : h.pc + 32'd4;
            if (mp) mq.delete();
`ifdef BRU_STATS_EN
            exp_br++;
            if (mp) exp_mc++;
`endif
        end
        if (push) begin
            n.pc = ppc; n.taken = pt; n.tgt = ptgt; n.state = ps;
            mq.push_back(n);
        end
        pred_valid = 0; res_valid = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (update !== 1'b0) begin bad++; $display("FAIL rst_update got=%0h exp=0", update); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rst_mp got=%0h exp=0", mispredict); end
        total++; if (upd_pc !== 32'h0 || upd_target !== 32'h0 || upd_state !== 2'b00 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL rst_data got=%0h/%0h/%0h/%0h exp=0", upd_pc, upd_target, upd_state, redirect_pc);
        end
        total++; if (q_empty !== 1'b1 || q_full !== 1'b0) begin
            bad++; $display("FAIL rst_flags got=e%0h f%0h exp=e1 f0", q_empty, q_full);
        end
    endtask

    task automatic test_correct_taken();
        do_reset();
        step(1, 32'h08, 1, 32'h24, 2'b10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h24);
        total++; if (update !== 1'b1) begin bad++; $display("FAIL c1_update got=%0h exp=1", update); end
        total++; if (upd_pc !== 32'h08) begin bad++; $display("FAIL c1_upd_pc got=%0h exp=8", upd_pc); end
        total++; if (upd_state !== 2'b11) begin bad++; $display("FAIL c1_state got=%0h exp=3", upd_state); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL c1_mp got=%0h exp=0", mispredict); end
        idle();
        total++; if (update !== 1'b0) begin bad++; $display("FAIL c1_pulse got=%0h exp=0", update); end
    endtask

    task automatic test_mispredict_dir();
        do_reset();
        step(1, 32'h08, 0, 32'h24, 2'b01, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h24);
        total++; if (upd_state !== 2'b10) begin bad++; $display("FAIL c2_state got=%0h exp=2", upd_state); end
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL c2_mp got=%0h exp=1", mispredict); end
        total++; if (redirect_pc !== 32'h24) begin bad++; $display("FAIL c2_redir got=%0h exp=24", redirect_pc); end
        idle();
        step(1, 32'h0C, 1, 32'h40, 2'b11, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h99);
        total++; if (upd_state !== 2'b10) begin bad++; $display("FAIL c3_state got=%0h exp=2", upd_state); end
        total++; if (upd_target !== 32'h40) begin bad++; $display("FAIL c3_tgt got=%0h exp=40", upd_target); end
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL c3_mp got=%0h exp=1", mispredict); end
        total++; if (redirect_pc !== 32'h10) begin bad++; $display("FAIL c3_redir got=%0h exp=10", redirect_pc); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(i * 4), 1, 32'h200 + 32'(i), 2'b10, 0, 0, 0);
        total++; if (q_full !== 1'b1) begin bad++; $display("FAIL c4_full got=%0h exp=1", q_full); end
        step(1, 32'h500, 1, 32'h600, 2'b10, 0, 0, 0);
        total++; if (q_full !== 1'b1) begin bad++; $display("FAIL c4_full5 got=%0h exp=1", q_full); end
        step(1, 32'h700, 1, 32'h800, 2'b10, 1, 1, 32'h200);
        total++; if (q_full !== 1'b1 || update !== 1'b1) begin
            bad++; $display("FAIL c4_pushpop got=f%0h u%0h exp=f1 u1", q_full, update);
        end
        // Drain: expect 0x104,0x108,0x10C then 0x700 (0x500 was dropped)
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1, 1, (i < 3) ? 32'h201 + 32'(i) : 32'h800);
            total++; if (upd_pc !== ((i < 3) ? 32'h104 + 32'(i * 4) : 32'h700) || mispredict !== 1'b0) begin
                bad++; $display("FAIL c4_drain%0d got=%0h mp%0h exp=%0h mp0", i, upd_pc, mispredict,
                                 (i < 3) ? 32'h104 + 32'(i * 4) : 32'h700);
            end
        end
        total++; if (q_empty !== 1'b1) begin bad++; $display("FAIL c4_empty got=%0h exp=1", q_empty); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 32'h100 + 32'(i * 4), 0, 32'h0, 2'b00, 0, 0, 0);
        total++; if (q_empty !== 1'b0) begin bad++; $display("FAIL c5_fill got=%0h exp=0", q_empty); end
        step(0, 0, 0, 0, 0, 1, 1, 32'h200);
        total++; if (mispredict !== 1'b1 || q_empty !== 1'b1) begin
            bad++; $display("FAIL c5_flush got=mp%0h e%0h exp=mp1 e1", mispredict, q_empty);
        end
        total++; if (upd_state !== 2'b01 || redirect_pc !== 32'h200) begin
            bad++; $display("FAIL c5_upd got=%0h/%0h exp=1/200", upd_state, redirect_pc);
        end
        step(1, 32'h300, 1, 32'h0, 2'b11, 0, 0, 0);
        total++; if (q_empty !== 1'b1) begin bad++; $display("FAIL c5_drop got=%0h exp=1", q_empty); end
    endtask

    task automatic test_empty_and_reset();
        do_reset();
        step(0, 0, 0, 0, 0, 1, 1, 32'h44);
        total++; if (update !== 1'b0 || mispredict !== 1'b0) begin
            bad++; $display("FAIL c6_emptypop got=u%0h mp%0h exp=0", update, mispredict);
        end
        step(1, 32'hFFFF_FFFC, 1, 32'h10, 2'b10, 0, 0, 0);
        step(1, 32'h20, 1, 32'h30, 2'b10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0);
        total++; if (redirect_pc !== 32'h0 || mispredict !== 1'b1 || upd_pc !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL c6_wrap got=%0h mp%0h exp=0 mp1", redirect_pc, mispredict);
        end
        idle();
        step(1, 32'h40, 1, 32'h50, 2'b10, 0, 0, 0);
        step(1, 32'h44, 0, 32'h54, 2'b01, 0, 0, 0);
        rst_n = 0; res_valid = 1; res_taken = 0; res_target = 0;
        @(posedge clk); #1;
        rst_n = 1; res_valid = 0;
        model_clear();
        total++; if (q_empty !== 1'b1 || q_full !== 1'b0) begin
            bad++; $display("FAIL c6_rst_flags got=e%0h f%0h exp=e1 f0", q_empty, q_full);
        end
        total++; if (update !== 1'b0 || mispredict !== 1'b0 || upd_pc !== 32'h0 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL c6_rst_out got=u%0h mp%0h pc%0h r%0h exp=0", update, mispredict, upd_pc, redirect_pc);
        end
        step(0, 0, 0, 0, 0, 1, 1, 32'h50);
        total++; if (update !== 1'b0) begin bad++; $display("FAIL c6_after_rst got=%0h exp=0", update); end
    endtask

    task automatic test_random();
        logic [31:0] rpc, rtg, rtgt;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rpc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            rtg  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            if (mq.size() > 0 && $urandom_range(0, 2) != 0) rtgt = mq[0].tgt;
            else rtgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            step(($urandom_range(0, 9) < 6), rpc, 1'($urandom), rtg, 2'($urandom),
                 ($urandom_range(0, 9) < 5), 1'($urandom), rtgt);
            total++; if (update !== exp_update) begin bad++; $display("FAIL rnd_update c%0d got=%0h exp=%0h", i, update, exp_update); end
            total++; if (mispredict !== exp_mp) begin bad++; $display("FAIL rnd_mp c%0d got=%0h exp=%0h", i, mispredict, exp_mp); end
            total++; if (upd_pc !== exp_upd_pc || upd_target !== exp_upd_tgt || upd_state !== exp_upd_state) begin
                bad++; $display("FAIL rnd_upd c%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, upd_pc, upd_target,
                                upd_state, exp_upd_pc, exp_upd_tgt, exp_upd_state);
            end
            total++; if (redirect_pc !== exp_redirect) begin bad++; $display("FAIL rnd_redir c%0d got=%0h exp=%0h", i, redirect_pc, exp_redirect); end
            total++; if (q_full !== (mq.size() == DEPTH) || q_empty !== (mq.size() == 0)) begin
                bad++; $display("FAIL rnd_flags c%0d got=f%0h e%0h exp=size %0d", i, q_full, q_empty, mq.size());
            end
`ifdef BRU_STATS_EN
            total++; if (br_count !== exp_br || mp_count !== exp_mc) begin
                bad++; $display("FAIL rnd_stats c%0d got=%0d/%0d exp=%0d/%0d", i, br_count, mp_count, exp_br, exp_mc);
            end
`endif
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_correct_taken();
        test_mispredict_dir();
        test_full();
        test_flush();
        test_empty_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
